// File: rtl/ir_tx_prog.sv
// Bus-programmable IR packet transmitter: start burst, select burst and four
// command bits (MSB first), each followed by a gap, on a programmable carrier.
module ir_tx_prog #(
    parameter logic [7:0] BASE_ADDR     = 8'h90,
    parameter int         PERIOD_CYCLES = 5_000_000,
    parameter int         DEF_HALF      = 625,
    parameter int         DEF_START     = 88,
    parameter int         DEF_SELECT    = 22,
    parameter int         DEF_GAP       = 40,
    parameter int         DEF_ASSERT    = 44,
    parameter int         DEF_DEASSERT  = 22
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ADDR_IN,
    input  logic       BUS_WE,
    input  logic [7:0] DATA_IN,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       PKT_DONE
);

    localparam int              CW          = $clog2(PERIOD_CYCLES + 1);
    localparam logic [CW-1:0]   PERIOD_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic [10:0]     HALF_RST    = 11'(DEF_HALF);
    localparam logic [7:0]      START_RST   = 8'(DEF_START);
    localparam logic [7:0]      SELECT_RST  = 8'(DEF_SELECT);
    localparam logic [7:0]      GAP_RST     = 8'(DEF_GAP);
    localparam logic [7:0]      ASSERT_RST  = 8'(DEF_ASSERT);
    localparam logic [7:0]      DEASSERT_RST = 8'(DEF_DEASSERT);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_GAP_A, S_SELECT, S_GAP_B, S_BIT, S_BIT_GAP
    } state_t;

    // Zero-valued lengths/half-periods behave as 1; result is segment clocks minus one.
    function automatic logic [19:0] seg_last(input logic [7:0] len, input logic [10:0] half);
        logic [8:0]  two_len;
        logic [10:0] h;
        two_len = (len == 8'd0) ? 9'd2 : {len, 1'b0};
        h       = (half == 11'd0) ? 11'd1 : half;
        return (20'(two_len) * 20'(h)) - 20'd1;
    endfunction

    function automatic logic [10:0] half_eff(input logic [10:0] half);
        return (half == 11'd0) ? 11'd1 : half;
    endfunction

    logic [3:0]    cmd_r;
    logic [7:0]    start_r, select_r, gap_r, assert_r, deassert_r;
    logic [10:0]   half_r;
    logic          enable_r, oneshot_r;
    logic [CW-1:0] period_cnt_r;

    logic [3:0]    cmd_sh_r;
    logic [7:0]    start_sh_r, select_sh_r, gap_sh_r, assert_sh_r, deassert_sh_r;
    logic [10:0]   half_sh_r;

    state_t        state_r;
    logic [19:0]   seg_cnt_r;
    logic [10:0]   half_cnt_r;
    logic [1:0]    bit_idx_r;
    logic          led_r, busy_r, done_r;

    logic [7:0]    offset_s;
    logic          wr_s, cont_s, trigger_s;
    logic          half_wrap_s, burst_s, nxt_burst_s;
    logic [1:0]    prev_idx_s;
    logic [7:0]    nxt_len_s;
    state_t        nxt_state_s;

    assign offset_s    = ADDR_IN - BASE_ADDR;
    assign wr_s        = BUS_WE && (offset_s < 8'd9);
    assign cont_s      = enable_r && !oneshot_r;
    assign trigger_s   = (cont_s && (period_cnt_r == PERIOD_LAST)) ||
                         (enable_r && oneshot_r && wr_s && (offset_s == 8'd8) && DATA_IN[2]);
    assign half_wrap_s = (half_cnt_r == (half_sh_r - 11'd1));
    assign burst_s     = (state_r == S_START) || (state_r == S_SELECT) || (state_r == S_BIT);
    assign prev_idx_s  = bit_idx_r - 2'd1;

    // Successor segment: which state, its length and whether it is a carrier burst.
    always_comb begin
        nxt_state_s = S_IDLE;
        nxt_len_s   = gap_sh_r;
        nxt_burst_s = 1'b0;
        case (state_r)
            S_START:   begin nxt_state_s = S_GAP_A;  nxt_len_s = gap_sh_r; end
            S_GAP_A:   begin nxt_state_s = S_SELECT; nxt_len_s = select_sh_r; nxt_burst_s = 1'b1; end
            S_SELECT:  begin nxt_state_s = S_GAP_B;  nxt_len_s = gap_sh_r; end
            S_GAP_B:   begin
                nxt_state_s = S_BIT;
                nxt_len_s   = cmd_sh_r[bit_idx_r] ? assert_sh_r : deassert_sh_r;
                nxt_burst_s = 1'b1;
            end
            S_BIT:     begin nxt_state_s = S_BIT_GAP; nxt_len_s = gap_sh_r; end
            S_BIT_GAP: begin
                nxt_state_s = S_BIT;
                nxt_len_s   = cmd_sh_r[prev_idx_s] ? assert_sh_r : deassert_sh_r;
                nxt_burst_s = 1'b1;
            end
            default:   begin nxt_state_s = S_IDLE; nxt_len_s = gap_sh_r; nxt_burst_s = 1'b0; end
        endcase
    end

    // Bus-writable register file.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_r      <= 4'd0;
            start_r    <= START_RST;
            select_r   <= SELECT_RST;
            gap_r      <= GAP_RST;
            assert_r   <= ASSERT_RST;
            deassert_r <= DEASSERT_RST;
            half_r     <= HALF_RST;
            enable_r   <= 1'b0;
            oneshot_r  <= 1'b0;
        end else if (wr_s) begin
            case (offset_s)
                8'd0:    cmd_r        <= DATA_IN[3:0];
                8'd1:    start_r      <= DATA_IN;
                8'd2:    select_r     <= DATA_IN;
                8'd3:    gap_r        <= DATA_IN;
                8'd4:    assert_r     <= DATA_IN;
                8'd5:    deassert_r   <= DATA_IN;
                8'd6:    half_r[7:0]  <= DATA_IN;
                8'd7:    half_r[10:8] <= DATA_IN[2:0];
                8'd8:    begin enable_r <= DATA_IN[0]; oneshot_r <= DATA_IN[1]; end
                default: cmd_r        <= cmd_r;
            endcase
        end
    end

    // Continuous-mode period counter, parked at zero outside continuous mode.
    always_ff @(posedge CLK) begin
        if (RST || !cont_s || (period_cnt_r == PERIOD_LAST)) begin
            period_cnt_r <= '0;
        end else begin
            period_cnt_r <= period_cnt_r + CW'(1);
        end
    end

    // Packet sequencer with shadowed timing and registered LED/BUSY/PKT_DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= S_IDLE;
            seg_cnt_r     <= 20'd0;
            half_cnt_r    <= 11'd0;
            bit_idx_r     <= 2'd0;
            led_r         <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            cmd_sh_r      <= 4'd0;
            start_sh_r    <= START_RST;
            select_sh_r   <= SELECT_RST;
            gap_sh_r      <= GAP_RST;
            assert_sh_r   <= ASSERT_RST;
            deassert_sh_r <= DEASSERT_RST;
            half_sh_r     <= HALF_RST;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    led_r  <= 1'b0;
                    busy_r <= 1'b0;
                    if (trigger_s) begin
                        cmd_sh_r      <= cmd_r;
                        start_sh_r    <= start_r;
                        select_sh_r   <= select_r;
                        gap_sh_r      <= gap_r;
                        assert_sh_r   <= assert_r;
                        deassert_sh_r <= deassert_r;
                        half_sh_r     <= half_eff(half_r);
                        seg_cnt_r     <= seg_last(start_r, half_r);
                        half_cnt_r    <= 11'd0;
                        bit_idx_r     <= 2'd3;
                        state_r       <= S_START;
                        led_r         <= 1'b1;
                        busy_r        <= 1'b1;
                    end
                end
                S_START, S_GAP_A, S_SELECT, S_GAP_B, S_BIT, S_BIT_GAP: begin
                    if (seg_cnt_r == 20'd0) begin
                        half_cnt_r <= 11'd0;
                        if ((state_r == S_BIT_GAP) && (bit_idx_r == 2'd0)) begin
                            state_r <= S_IDLE;
                            led_r   <= 1'b0;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= nxt_state_s;
                            seg_cnt_r <= seg_last(nxt_len_s, half_sh_r);
                            led_r     <= nxt_burst_s;
                            if (state_r == S_BIT_GAP) begin
                                bit_idx_r <= prev_idx_s;
                            end
                        end
                    end else begin
                        seg_cnt_r  <= seg_cnt_r - 20'd1;
                        half_cnt_r <= half_wrap_s ? 11'd0 : (half_cnt_r + 11'd1);
                        if (burst_s && half_wrap_s) begin
                            led_r <= ~led_r;
                        end
                        // Gaps last at least two clocks, so the final cycle is always foreseeable.
                        done_r <= (state_r == S_BIT_GAP) && (bit_idx_r == 2'd0) && (seg_cnt_r == 20'd1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    led_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign IR_LED   = led_r;
    assign BUSY     = busy_r;
    assign PKT_DONE = done_r;

endmodule

// File: tb/tb_ir_tx_prog.sv
// Scoreboard bench for ir_tx_prog: a cycle-level reference of each packet is
// queued at trigger time and compared against {IR_LED, BUSY, PKT_DONE}.
module tb_ir_tx_prog;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
    logic       ir_led;
    logic       busy;
    logic       pkt_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         at;
        logic [3:0] off;
        logic [7:0] d;
    } wr_t;

    logic [2:0] exp_q[$];
    wr_t        sched_q[$];

    ir_tx_prog #(.PERIOD_CYCLES(200)) dut (
        .CLK(clk), .RST(rst), .ADDR_IN(addr), .BUS_WE(we), .DATA_IN(data),
        .IR_LED(ir_led), .BUSY(busy), .PKT_DONE(pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [7:0] d);
        addr = 8'h90 + {4'h0, off};
        data = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        addr = 8'h00;
    endtask

    task automatic gen_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
    endtask

    // Reference packet: lengths/half are effective (non-zero) values.
    task automatic gen_packet(input logic [3:0] cmd, input int st, input int sel, input int gap,
                              input int as, input int de, input int half, input int limit);
        int seg_len[12];
        bit seg_burst[12];
        int total;
        int n;
        seg_len[0] = st;  seg_burst[0] = 1'b1;
        seg_len[1] = gap; seg_burst[1] = 1'b0;
        seg_len[2] = sel; seg_burst[2] = 1'b1;
        seg_len[3] = gap; seg_burst[3] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            seg_len[4 + 2*b]   = cmd[3-b] ? as : de;
            seg_burst[4 + 2*b] = 1'b1;
            seg_len[5 + 2*b]   = gap;
            seg_burst[5 + 2*b] = 1'b0;
        end
        total = 0;
        for (int s = 0; s < 12; s++) total += 2 * seg_len[s] * half;
        n = 0;
        for (int s = 0; s < 12; s++) begin
            for (int c = 0; c < 2 * seg_len[s] * half; c++) begin
                if (n < limit) begin
                    exp_q.push_back({seg_burst[s] && (((c / half) % 2) == 0), 1'b1, n == total - 1});
                end
                n++;
            end
        end
    endtask

    // Compare queued expectations cycle by cycle, driving any scheduled bus writes.
    task automatic check_stream(input string name);
        logic [2:0] e;
        logic [2:0] obs;
        wr_t        w;
        int         i;
        i = 0;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = {ir_led, busy, pkt_done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s cycle %0d: led/busy/done got %b expected %b", name, i, obs, e);
                exp_q.delete();
            end
            if (sched_q.size() > 0 && sched_q[0].at == i) begin
                w    = sched_q.pop_front();
                addr = 8'h90 + {4'h0, w.off};
                data = w.d;
                we   = 1'b1;
            end else begin
                we = 1'b0;
            end
            tick();
            i++;
        end
        we = 1'b0;
        sched_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({ir_led, busy, pkt_done} !== 3'b000) begin
            failures++;
            $display("FAIL %s: led/busy/done got %b expected 000", name, {ir_led, busy, pkt_done});
        end
    endtask

    task automatic pulse_reset(input string name);
        rst = 1'b1;
        tick();
        check_reset_outputs(name);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; addr = 8'h00; data = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset_state");
        rst = 1'b0;
        gen_idle(20);
        check_stream("idle_after_reset");
        bus_write(4'd8, 8'h04);
        gen_idle(10);
        check_stream("trigger_while_disabled");
    endtask

    task automatic test_default_carrier();
        bus_write(4'd8, 8'h03);
        bus_write(4'd8, 8'h07);
        gen_packet(4'h0, 88, 22, 40, 44, 22, 625, 2500);
        sched_q.push_back('{100, 4'd6, 8'd10});
        check_stream("default_carrier");
        pulse_reset("reset_mid_burst");
        bus_write(4'd8, 8'h03);
        bus_write(4'd8, 8'h07);
        gen_packet(4'h0, 88, 22, 40, 44, 22, 625, 1300);
        check_stream("half_default_after_reset");
        pulse_reset("reset_second");
    endtask

    task automatic test_default_lengths();
        bus_write(4'd6, 8'd1);
        bus_write(4'd7, 8'd0);
        bus_write(4'd8, 8'h03);
        bus_write(4'd8, 8'h07);
        gen_packet(4'h0, 88, 22, 40, 44, 22, 1, 100000);
        gen_idle(4);
        check_stream("default_lengths_half1");
    endtask

    task automatic program_small();
        bus_write(4'd6, 8'd2);
        bus_write(4'd7, 8'd0);
        bus_write(4'd1, 8'd2);
        bus_write(4'd2, 8'd1);
        bus_write(4'd3, 8'd1);
        bus_write(4'd4, 8'd2);
        bus_write(4'd5, 8'd1);
        bus_write(4'd0, 8'h0A);
    endtask

    task automatic test_back_to_back();
        program_small();
        bus_write(4'd8, 8'h07);
        gen_packet(4'hA, 2, 1, 1, 2, 1, 2, 1000);
        gen_idle(3);
        sched_q.push_back('{10, 4'd0, 8'h01});
        sched_q.push_back('{20, 4'd4, 8'd5});
        sched_q.push_back('{30, 4'd8, 8'h07});
        sched_q.push_back('{59, 4'd8, 8'h07});
        check_stream("small_packet_shadowed");
        bus_write(4'd8, 8'h07);
        gen_packet(4'h1, 2, 1, 1, 5, 1, 2, 1000);
        gen_idle(2);
        check_stream("next_packet_new_values");
    endtask

    task automatic test_zero_values();
        for (int r = 1; r < 8; r++) bus_write(4'(r), 8'd0);
        bus_write(4'd0, 8'h05);
        bus_write(4'd8, 8'h07);
        gen_packet(4'h5, 1, 1, 1, 1, 1, 1, 1000);
        gen_idle(2);
        check_stream("zero_as_one");
    endtask

    task automatic test_continuous();
        program_small();
        bus_write(4'd8, 8'h01);
        gen_idle(200);
        gen_packet(4'hA, 2, 1, 1, 2, 1, 2, 1000);
        gen_idle(140);
        gen_packet(4'hA, 2, 1, 1, 2, 1, 2, 1000);
        gen_idle(400);
        sched_q.push_back('{410, 4'd8, 8'h00});
        check_stream("continuous_and_disable");
    endtask

    initial begin
        test_reset();
        test_default_carrier();
        test_default_lengths();
        test_back_to_back();
        test_zero_values();
        test_continuous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
